// File: rtl/isoiec7816_pkg.sv
// Shared definitions for the ISO/IEC 7816 interface-device blocks:
// ATR parser states, TS constants, error codes and interface-byte defaults.
package isoiec7816_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TS,
      ST_T0,
      ST_TA,
      ST_TB,
      ST_TC,
      ST_TD,
      ST_HIST,
      ST_TCK,
      ST_DONE,
      ST_ERROR
   } atr_state_t;

   localparam logic [7:0] TS_DIRECT      = 8'h3B;
   localparam logic [7:0] TS_INVERSE_RAW = 8'h03;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_BAD_TS   = 2'd1;
   localparam logic [1:0] ERR_TCK      = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW = 2'd3;

   localparam logic [7:0] TA1_DEFAULT = 8'h11;
   localparam logic [7:0] TC2_DEFAULT = 8'd10;

   // Next field to expect, given the interface bytes still pending in the
   // current group (bit0=TA .. bit3=TD) and what follows the interface bytes.
   function automatic atr_state_t next_field(input logic [3:0] y_rem,
                                             input logic       hist_pending,
                                             input logic       tck_pending);
      if (y_rem[0])          return ST_TA;
      else if (y_rem[1])     return ST_TB;
      else if (y_rem[2])     return ST_TC;
      else if (y_rem[3])     return ST_TD;
      else if (hist_pending) return ST_HIST;
      else if (tck_pending)  return ST_TCK;
      else                   return ST_DONE;
   endfunction

endpackage

// File: rtl/isoiec7816_atr_parser.sv
// Answer-To-Reset decoder: detects the convention, extracts the global
// interface bytes, protocol set and historical count, and verifies TCK.
module isoiec7816_atr_parser
   import isoiec7816_pkg::*;
#(
   parameter int MAX_LEN = 33
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  char,
   input  logic        received,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  error_code,
   output logic        inverse,
   output logic [7:0]  ta1,
   output logic [7:0]  tb1,
   output logic [7:0]  tc1,
   output logic [7:0]  ta2,
   output logic        ta2_present,
   output logic [7:0]  tc2,
   output logic [15:0] protocols,
   output logic [3:0]  hist_count,
   output logic [5:0]  char_count
);

   localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

   atr_state_t  state, state_d;
   logic        busy_d, done_d, error_d, inverse_d, ta2_present_d, tck_req, tck_req_d;
   logic [1:0]  error_code_d, idx, idx_d;
   logic [7:0]  ta1_d, tb1_d, tc1_d, ta2_d, tc2_d, chk, chk_d;
   logic [15:0] protocols_d;
   logic [3:0]  hist_count_d, hist_left, hist_left_d, y_mask, y_mask_d;
   logic [5:0]  char_count_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         error_code  <= ERR_NONE;
         inverse     <= 1'b0;
         ta1         <= TA1_DEFAULT;
         tb1         <= '0;
         tc1         <= '0;
         ta2         <= '0;
         ta2_present <= 1'b0;
         tc2         <= TC2_DEFAULT;
         protocols   <= '0;
         hist_count  <= '0;
         char_count  <= '0;
         hist_left   <= '0;
         y_mask      <= '0;
         idx         <= '0;
         tck_req     <= 1'b0;
         chk         <= '0;
      end else begin
         state       <= state_d;
         busy        <= busy_d;
         done        <= done_d;
         error       <= error_d;
         error_code  <= error_code_d;
         inverse     <= inverse_d;
         ta1         <= ta1_d;
         tb1         <= tb1_d;
         tc1         <= tc1_d;
         ta2         <= ta2_d;
         ta2_present <= ta2_present_d;
         tc2         <= tc2_d;
         protocols   <= protocols_d;
         hist_count  <= hist_count_d;
         char_count  <= char_count_d;
         hist_left   <= hist_left_d;
         y_mask      <= y_mask_d;
         idx         <= idx_d;
         tck_req     <= tck_req_d;
         chk         <= chk_d;
      end
   end

   always_comb begin
      state_d       = state;
      busy_d        = busy;
      done_d        = done;
      error_d       = error;
      error_code_d  = error_code;
      inverse_d     = inverse;
      ta1_d         = ta1;
      tb1_d         = tb1;
      tc1_d         = tc1;
      ta2_d         = ta2;
      ta2_present_d = ta2_present;
      tc2_d         = tc2;
      protocols_d   = protocols;
      hist_count_d  = hist_count;
      char_count_d  = char_count;
      hist_left_d   = hist_left;
      y_mask_d      = y_mask;
      idx_d         = idx;
      tck_req_d     = tck_req;
      chk_d         = chk;

      if (start) begin
         state_d       = ST_TS;
         busy_d        = 1'b1;
         done_d        = 1'b0;
         error_d       = 1'b0;
         error_code_d  = ERR_NONE;
         inverse_d     = 1'b0;
         ta1_d         = TA1_DEFAULT;
         tb1_d         = '0;
         tc1_d         = '0;
         ta2_d         = '0;
         ta2_present_d = 1'b0;
         tc2_d         = TC2_DEFAULT;
         protocols_d   = '0;
         hist_count_d  = '0;
         char_count_d  = '0;
         hist_left_d   = '0;
         y_mask_d      = '0;
         idx_d         = '0;
         tck_req_d     = 1'b0;
         chk_d         = '0;
      end else if (received && busy) begin
         if (char_count == MAX_CNT) begin
            state_d      = ST_ERROR;
            error_code_d = ERR_OVERFLOW;
         end else begin
            char_count_d = char_count + 6'd1;
            if (state != ST_TS) chk_d = chk ^ char;
            unique case (state)
               ST_TS: begin
                  if (char == TS_DIRECT) begin
                     state_d = ST_T0;
                  end else if (char == TS_INVERSE_RAW) begin
                     inverse_d = 1'b1;
                     state_d   = ST_T0;
                  end else begin
                     state_d      = ST_ERROR;
                     error_code_d = ERR_BAD_TS;
                  end
               end
               ST_T0: begin
                  hist_count_d = char[3:0];
                  hist_left_d  = char[3:0];
                  y_mask_d     = char[7:4];
                  idx_d        = 2'd1;
                  if (!char[7]) protocols_d[0] = 1'b1;
                  state_d = next_field(char[7:4], char[3:0] != 4'd0, 1'b0);
               end
               ST_TA: begin
                  if (idx == 2'd1) ta1_d = char;
                  if (idx == 2'd2) begin
                     ta2_d         = char;
                     ta2_present_d = 1'b1;
                  end
                  y_mask_d = {y_mask[3:1], 1'b0};
                  state_d  = next_field(y_mask_d, hist_count != 4'd0, tck_req);
               end
               ST_TB: begin
                  if (idx == 2'd1) tb1_d = char;
                  y_mask_d = {y_mask[3:2], 2'b00};
                  state_d  = next_field(y_mask_d, hist_count != 4'd0, tck_req);
               end
               ST_TC: begin
                  if (idx == 2'd1) tc1_d = char;
                  if (idx == 2'd2) tc2_d = char;
                  y_mask_d = {y_mask[3], 3'b000};
                  state_d  = next_field(y_mask_d, hist_count != 4'd0, tck_req);
               end
               ST_TD: begin
                  protocols_d[char[3:0]] = 1'b1;
                  if (char[3:0] != 4'd0) tck_req_d = 1'b1;
                  y_mask_d = char[7:4];
                  // only groups 1 and 2 carry stored bytes, so the index saturates
                  if (idx != 2'd3) idx_d = idx + 2'd1;
                  state_d = next_field(char[7:4], hist_count != 4'd0, tck_req_d);
               end
               ST_HIST: begin
                  hist_left_d = hist_left - 4'd1;
                  if (hist_left == 4'd1) state_d = tck_req ? ST_TCK : ST_DONE;
               end
               ST_TCK: begin
                  if (chk_d == 8'd0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d      = ST_ERROR;
                     error_code_d = ERR_TCK;
                  end
               end
               default: state_d = state;
            endcase
         end
         if (state_d == ST_DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         if (state_d == ST_ERROR) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_isoiec7816_atr_parser.sv
// Self-checking bench for isoiec7816_atr_parser: directed and random ATRs
// against a field-queue reference model, on MAX_LEN=33 and MAX_LEN=4 instances.
module tb_isoiec7816_atr_parser;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        error;
      logic [1:0]  code;
      logic        inverse;
      logic [7:0]  ta1;
      logic [7:0]  tb1;
      logic [7:0]  tc1;
      logic [7:0]  ta2;
      logic        ta2p;
      logic [7:0]  tc2;
      logic [15:0] prot;
      logic [3:0]  hist;
      logic [5:0]  cnt;
   } res_t;

   typedef struct {
      int kind;  // 0 TA, 1 TB, 2 TC, 3 TD, 4 historical, 5 TCK
      int grp;
   } field_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       received = 1'b0;
   logic [7:0] char = 8'h00;

   res_t obs_a, obs_b;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clock = ~clock;

   isoiec7816_atr_parser #(.MAX_LEN(33)) dut_a (
      .clock(clock), .reset(reset), .start(start), .char(char), .received(received),
      .busy(obs_a.busy), .done(obs_a.done), .error(obs_a.error), .error_code(obs_a.code),
      .inverse(obs_a.inverse), .ta1(obs_a.ta1), .tb1(obs_a.tb1), .tc1(obs_a.tc1),
      .ta2(obs_a.ta2), .ta2_present(obs_a.ta2p), .tc2(obs_a.tc2), .protocols(obs_a.prot),
      .hist_count(obs_a.hist), .char_count(obs_a.cnt)
   );

   isoiec7816_atr_parser #(.MAX_LEN(4)) dut_b (
      .clock(clock), .reset(reset), .start(start), .char(char), .received(received),
      .busy(obs_b.busy), .done(obs_b.done), .error(obs_b.error), .error_code(obs_b.code),
      .inverse(obs_b.inverse), .ta1(obs_b.ta1), .tb1(obs_b.tb1), .tc1(obs_b.tc1),
      .ta2(obs_b.ta2), .ta2_present(obs_b.ta2p), .tc2(obs_b.tc2), .protocols(obs_b.prot),
      .hist_count(obs_b.hist), .char_count(obs_b.cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic res_t idle_result(input bit armed);
      res_t r;
      r = '0;
      r.busy = armed;
      r.ta1  = 8'h11;
      r.tc2  = 8'd10;
      return r;
   endfunction

   // Reference: walk the ATR as a queue of expected fields built from Y/TD/K.
   function automatic res_t model(input logic [7:0] q[$], input int n, input int maxlen);
      res_t       r;
      field_t     pend[$];
      field_t     f;
      bit         fin, tail, tck;
      logic [7:0] x, c;
      r = idle_result(1'b1);
      fin = 0; tail = 0; tck = 0; x = 8'h00;
      for (int k = 0; k < n && !fin; k++) begin
         c = q[k];
         if (k >= maxlen) begin
            r.error = 1'b1; r.code = 2'd3; fin = 1;
         end else begin
            r.cnt = 6'(k + 1);
            if (k == 0) begin
               if (c == 8'h03) r.inverse = 1'b1;
               else if (c != 8'h3B) begin r.error = 1'b1; r.code = 2'd1; fin = 1; end
            end else begin
               x ^= c;
               if (k == 1) begin
                  r.hist = c[3:0];
                  if (!c[7]) r.prot[0] = 1'b1;
                  for (int b = 0; b < 4; b++) if (c[4+b]) pend.push_back('{b, 1});
               end else begin
                  f = pend.pop_front();
                  case (f.kind)
                     0: begin
                        if (f.grp == 1) r.ta1 = c;
                        if (f.grp == 2) begin r.ta2 = c; r.ta2p = 1'b1; end
                     end
                     1: if (f.grp == 1) r.tb1 = c;
                     2: begin
                        if (f.grp == 1) r.tc1 = c;
                        if (f.grp == 2) r.tc2 = c;
                     end
                     3: begin
                        r.prot[c[3:0]] = 1'b1;
                        if (c[3:0] != 4'd0) tck = 1;
                        for (int b = 0; b < 4; b++) if (c[4+b]) pend.push_back('{b, f.grp + 1});
                     end
                     5: begin
                        if (x != 8'h00) begin r.error = 1'b1; r.code = 2'd2; end
                        else r.done = 1'b1;
                        fin = 1;
                     end
                     default: ;
                  endcase
               end
               if (!fin && pend.size() == 0 && !tail) begin
                  tail = 1;
                  for (int h = 0; h < int'(r.hist); h++) pend.push_back('{4, 0});
                  if (tck) pend.push_back('{5, 0});
               end
               if (!fin && pend.size() == 0) begin r.done = 1'b1; fin = 1; end
            end
         end
      end
      if (fin) r.busy = 1'b0;
      return r;
   endfunction

   task automatic check_res(input string p, input res_t o, input res_t e, input bit full);
      check_eq({p, ".busy"}, 32'(o.busy), 32'(e.busy));
      check_eq({p, ".done"}, 32'(o.done), 32'(e.done));
      check_eq({p, ".error"}, 32'(o.error), 32'(e.error));
      check_eq({p, ".error_code"}, 32'(o.code), 32'(e.code));
      check_eq({p, ".char_count"}, 32'(o.cnt), 32'(e.cnt));
      if (full) begin
         check_eq({p, ".inverse"}, 32'(o.inverse), 32'(e.inverse));
         check_eq({p, ".ta1"}, 32'(o.ta1), 32'(e.ta1));
         check_eq({p, ".tb1"}, 32'(o.tb1), 32'(e.tb1));
         check_eq({p, ".tc1"}, 32'(o.tc1), 32'(e.tc1));
         check_eq({p, ".ta2"}, 32'(o.ta2), 32'(e.ta2));
         check_eq({p, ".ta2_present"}, 32'(o.ta2p), 32'(e.ta2p));
         check_eq({p, ".tc2"}, 32'(o.tc2), 32'(e.tc2));
         check_eq({p, ".protocols"}, 32'(o.prot), 32'(e.prot));
         check_eq({p, ".hist_count"}, 32'(o.hist), 32'(e.hist));
      end
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic run_atr(input string name, input logic [7:0] q[$], input bit gaps);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check_res({name, "/a.start"}, obs_a, model(q, 0, 33), 1'b1);
      check_res({name, "/b.start"}, obs_b, model(q, 0, 4), 1'b1);
      for (int k = 0; k < q.size(); k++) begin
         if (gaps && $urandom_range(0, 2) == 0) @(negedge clock);
         char = q[k];
         received = 1'b1;
         @(negedge clock);
         received = 1'b0;
         check_res($sformatf("%s/a.c%0d", name, k), obs_a, model(q, k + 1, 33), 1'b0);
         check_res($sformatf("%s/b.c%0d", name, k), obs_b, model(q, k + 1, 4), 1'b0);
      end
      @(negedge clock);
      check_res({name, "/a.end"}, obs_a, model(q, q.size(), 33), 1'b1);
      check_res({name, "/b.end"}, obs_b, model(q, q.size(), 4), 1'b1);
   endtask

   task automatic gen_atr(output logic [7:0] q[$]);
      logic [3:0] y, k, t, ny;
      logic [7:0] x;
      int         r, grp;
      bit         tck;
      q.delete();
      r = $urandom_range(0, 9);
      if (r == 0)     q.push_back(8'($urandom));
      else if (r < 4) q.push_back(8'h03);
      else            q.push_back(8'h3B);
      y = 4'($urandom_range(0, 15));
      k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      q.push_back({y, k});
      grp = 1; tck = 0;
      while (1) begin
         for (int b = 0; b < 3; b++) if (y[b]) q.push_back(8'($urandom));
         if (!y[3]) break;
         t  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
         ny = (grp >= 4) ? 4'd0 : 4'($urandom_range(0, 15));
         q.push_back({ny, t});
         if (t != 4'd0) tck = 1;
         y = ny;
         grp++;
      end
      for (int h = 0; h < int'(k); h++) q.push_back(8'($urandom));
      if (tck) begin
         x = 8'h00;
         for (int i = 1; i < q.size(); i++) x ^= q[i];
         if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
         q.push_back(x);
      end
      if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom));
   endtask

   initial begin
      logic [7:0] q[$];
      repeat (3) @(negedge clock);
      check_res("reset/a", obs_a, idle_result(1'b0), 1'b1);
      check_res("reset/b", obs_b, idle_result(1'b0), 1'b1);
      reset = 1'b1;
      @(negedge clock);

      // received while idle must be ignored
      char = 8'h3B; received = 1'b1;
      @(negedge clock);
      received = 1'b0;
      check_res("idle_rx/a", obs_a, idle_result(1'b0), 1'b1);

      q = '{8'h3B, 8'h00};                          run_atr("min", q, 1'b0);
      q = '{8'h3B, 8'h80, 8'h01, 8'h81};            run_atr("t1ok", q, 1'b0);
      q = '{8'h3B, 8'h80, 8'h01, 8'h82};            run_atr("t1bad", q, 1'b0);
      q = '{8'h3B, 8'h12, 8'h96, 8'h41, 8'h42};     run_atr("hist", q, 1'b0);
      q = '{8'h55};                                 run_atr("badts", q, 1'b0);
      q = '{8'h03, 8'h00};                          run_atr("inv", q, 1'b0);
      q = '{8'h3B, 8'h0F, 8'h01, 8'h02, 8'h03};     run_atr("ovf", q, 1'b0);
      q = '{8'h3B, 8'hF0, 8'h97, 8'h01, 8'h02, 8'hF1, 8'h18, 8'h22, 8'h33, 8'h00, 8'h00};
      run_atr("grp2", q, 1'b1);

      // asynchronous reset in the middle of an ATR
      start = 1'b1; @(negedge clock); start = 1'b0;
      char = 8'h3B; received = 1'b1; @(negedge clock);
      char = 8'h80; @(negedge clock); received = 1'b0;
      #2 reset = 1'b0;
      #1 check_res("async_rst/a", obs_a, idle_result(1'b0), 1'b1);
      check_res("async_rst/b", obs_b, idle_result(1'b0), 1'b1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      q = '{8'h3B, 8'h00};                          run_atr("after_rst", q, 1'b0);

      // start coincident with received: the character is dropped
      start = 1'b1; char = 8'h3B; received = 1'b1;
      @(negedge clock);
      start = 1'b0; received = 1'b0;
      check_res("start_rx/a", obs_a, idle_result(1'b1), 1'b1);
      check_res("start_rx/b", obs_b, idle_result(1'b1), 1'b1);
      q = '{8'h3B, 8'h00};                          run_atr("post_start_rx", q, 1'b0);

      for (int i = 0; i < 60; i++) begin
         gen_atr(q);
         run_atr($sformatf("rnd%0d", i), q, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
